// File: rtl/codegen_seq.sv
// Burst sequencer for an external code generator: clears it, issues prescaled
// count enables for a programmed number of pulses, then samples its value.
module codegen_seq #(
  parameter int PRESC_W = 8,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PRESC_W-1:0] presc,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic [15:0]        gen_data,
  output logic               gen_ena,
  output logic               gen_clr,
  output logic               busy,
  output logic               done,
  output logic               sat,
  output logic [15:0]        sample,
  output logic               sample_vld
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] presc_q, presc_cnt;
  logic [LEN_W-1:0]   len_q, pulse_cnt;
  logic [15:0]        sample_q;
  logic               sat_q;
  logic               full;
  logic               tick;

  assign full = (gen_data == 16'hFFFF);

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: state_nxt = stop ? DRAIN : RUN;
      RUN: begin
        // saturation beats stop, stop beats a prescale tick
        if (full || stop) begin
          state_nxt = DRAIN;
        end else if (presc_cnt == '0) begin
          tick = 1'b1;
          if (len_q != '0 && (pulse_cnt + LEN_W'(1)) == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gen_ena    = tick;
  assign gen_clr    = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign sample_vld = (state == DRAIN);
  assign sat        = sat_q;
  // the captured value is already visible during the sample_vld cycle
  assign sample     = (state == DRAIN) ? gen_data : sample_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc_q   <= '0;
      len_q     <= '0;
      presc_cnt <= '0;
      pulse_cnt <= '0;
      sample_q  <= '0;
      sat_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            presc_q <= presc;
            len_q   <= burst_len;
            sat_q   <= 1'b0;
          end
        end
        CLEAR: begin
          presc_cnt <= presc_q;
          pulse_cnt <= '0;
        end
        RUN: begin
          if (full) begin
            sat_q <= 1'b1;
          end else if (tick) begin
            presc_cnt <= presc_q;
            if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + LEN_W'(1);
          end else if (!stop) begin
            presc_cnt <= presc_cnt - PRESC_W'(1);
          end
        end
        DRAIN: sample_q <= gen_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codegen_seq.sv
// Directed bench for codegen_seq with a behavioural up-counter as the generator.
module tb_codegen_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  presc = '0;
  logic [15:0] burst_len = '0;
  logic [15:0] gen_data;
  logic        gen_ena, gen_clr, busy, done, sat, sample_vld;
  logic [15:0] sample;

  logic [15:0] gen_cnt = '0;
  logic [15:0] clr_val = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  codegen_seq #(.PRESC_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .presc(presc),
    .burst_len(burst_len), .gen_data(gen_data), .gen_ena(gen_ena),
    .gen_clr(gen_clr), .busy(busy), .done(done), .sat(sat),
    .sample(sample), .sample_vld(sample_vld)
  );

  // generator model: synchronous clear to clr_val, count on gen_ena
  always_ff @(posedge clk) begin
    if (gen_clr) gen_cnt <= clr_val;
    else if (gen_ena) gen_cnt <= gen_cnt + 16'd1;
  end
  assign gen_data = gen_cnt;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    repeat (3) cyc();
    obs = {busy, gen_clr, gen_ena, sample_vld, done};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b want %b", obs, 5'b0); end
    checks++;
    if (sat !== 1'b0 || sample !== 16'h0000) begin
      errors++; $display("FAIL reset_regs: got sat=%b sample=%h want sat=0 sample=0000", sat, sample);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [4:0] obs, exp;
    clr_val = 16'h0000; presc = 8'd0; burst_len = 16'd3; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      start = 1'b0;
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 6), (c == 1), (c >= 2 && c <= 4), (c == 5), (c == 6)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL basic_trace c%0d: got %b want %b", c, obs, exp); end
      if (c == 5) begin
        checks++;
        if (sample !== 16'h0003) begin errors++; $display("FAIL basic_sample_vld: got %h want 0003", sample); end
      end
    end
    checks++;
    if (sample !== 16'h0003 || sat !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got sample=%h sat=%b want 0003 0", sample, sat);
    end
  endtask

  task automatic test_presc();
    logic [4:0] obs, exp;
    presc = 8'd2; burst_len = 16'd2; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      start = 1'b0;
      if (c == 3) begin presc = 8'd0; burst_len = 16'd1; end
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 9), (c == 1), (c == 4 || c == 7), (c == 8), (c == 9)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL presc_trace c%0d: got %b want %b", c, obs, exp); end
    end
    checks++;
    if (sample !== 16'h0002) begin errors++; $display("FAIL presc_sample: got %h want 0002", sample); end
  endtask

  task automatic test_unlimited_stop();
    logic [4:0] obs, exp;
    presc = 8'd0; burst_len = 16'd0; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      start = 1'b0;
      stop = (c == 6);
      #1;
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 8), (c == 1), (c >= 2 && c <= 5), (c == 7), (c == 8)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stop_trace c%0d: got %b want %b", c, obs, exp); end
    end
    stop = 1'b0;
    checks++;
    if (sample !== 16'h0004 || sat !== 1'b0) begin
      errors++; $display("FAIL stop_result: got sample=%h sat=%b want 0004 0", sample, sat);
    end
  endtask

  task automatic test_sat();
    logic [4:0] obs, exp;
    clr_val = 16'hFFFD; presc = 8'd0; burst_len = 16'd0; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 6), (c == 1), (c == 2 || c == 3), (c == 5), (c == 6)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sat_trace c%0d: got %b want %b", c, obs, exp); end
      checks++;
      if (sat !== (c >= 5)) begin errors++; $display("FAIL sat_flag c%0d: got %b want %b", c, sat, (c >= 5)); end
    end
    checks++;
    if (sample !== 16'hFFFF) begin errors++; $display("FAIL sat_sample: got %h want ffff", sample); end
    clr_val = 16'h0000; burst_len = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (sat !== 1'b0 || gen_clr !== 1'b1) begin
      errors++; $display("FAIL sat_clear: got sat=%b clr=%b want 0 1", sat, gen_clr);
    end
    repeat (4) cyc();
    checks++;
    if (busy !== 1'b0 || sample !== 16'h0001) begin
      errors++; $display("FAIL sat_rerun: got busy=%b sample=%h want 0 0001", busy, sample);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    presc = 8'd0; burst_len = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    obs = {busy, gen_clr, gen_ena, sample_vld, done};
    checks++;
    if (obs !== 5'b0 || sat !== 1'b0 || sample !== 16'h0000) begin
      errors++; $display("FAIL async_reset: got %b sat=%b sample=%h want 00000 0 0000", obs, sat, sample);
    end
    repeat (2) begin
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_hold: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    rst_n = 1'b1; burst_len = 16'd1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      start = 1'b0;
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 4), (c == 1), (c == 2), (c == 3), (c == 4)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL post_reset c%0d: got %b want %b", c, obs, exp); end
    end
    checks++;
    if (sample !== 16'h0001) begin errors++; $display("FAIL post_reset_sample: got %h want 0001", sample); end
  endtask

  task automatic test_ignore();
    logic [4:0] obs, exp;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_stop: got busy=%b want 0", busy); end
    presc = 8'd1; burst_len = 16'd2; start = 1'b1; stop = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      start = (c == 3 || c == 4 || c == 7);
      stop  = (c == 6 || c == 7);
      #1;
      obs = {busy, gen_clr, gen_ena, sample_vld, done};
      exp = {(c >= 1 && c <= 7), (c == 1), (c == 3 || c == 5), (c == 6), (c == 7)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ignore_trace c%0d: got %b want %b", c, obs, exp); end
    end
    start = 1'b0; stop = 1'b0;
    checks++;
    if (sample !== 16'h0002) begin errors++; $display("FAIL ignore_sample: got %h want 0002", sample); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_presc();
    test_unlimited_stop();
    test_sat();
    test_reset_mid();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codegen_seq.md
CODEGEN_SEQ -- requirements
Module: codegen_seq

Interface
REQ-001 SHALL have parameter PRESC_W, default 8, prescaler width.
REQ-002 SHALL have parameter LEN_W, default 16, burst-length width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle command that begins a burst.
REQ-006 SHALL have port stop  input  1  one-cycle command that aborts a burst.
REQ-007 SHALL have port presc  input  PRESC_W  gap between enables: one gen_ena per presc+1 RUN cycles.
REQ-008 SHALL have port burst_len  input  LEN_W  number of gen_ena pulses; 0 = unlimited.
REQ-009 SHALL have port gen_data  input  16  counter value from the code generator.
REQ-010 SHALL have port gen_ena  output  1  count enable to the generator.
REQ-011 SHALL have port gen_clr  output  1  active-high clear to the generator's reset.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle end-of-burst pulse.
REQ-014 SHALL have port sat  output  1  sticky flag: generator reached 16'hFFFF.
REQ-015 SHALL have port sample  output  16  gen_data captured at end of burst.
REQ-016 SHALL have port sample_vld  output  1  one-cycle pulse when sample updates.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-018 IDLE: start -> CLEAR; latch presc and burst_len; clear sat; stop ignored; start+stop together -> start wins.
REQ-019 CLEAR (1 cycle): gen_clr=1; prescale counter <= latched presc; pulse counter <= 0; next RUN, or DRAIN if stop is high.
REQ-020 RUN: prescale counter==0 -> gen_ena=1 for that cycle, counter reloads presc, pulse counter +1; otherwise counter decrements and gen_ena=0.
REQ-021 RUN: after the gen_ena where pulse counter+1 == latched burst_len (burst_len!=0) -> DRAIN next cycle.
REQ-022 RUN: stop -> DRAIN; gen_ena forced 0 that cycle even on a prescale tick (stop wins).
REQ-023 RUN: gen_data==16'hFFFF -> sat<=1, gen_ena forced 0, -> DRAIN; takes priority over tick and burst completion.
REQ-024 DRAIN (1 cycle): sample<=gen_data, sample_vld=1, -> DONE.
REQ-025 DONE (1 cycle): done=1, -> IDLE.
REQ-026 start outside IDLE SHALL be ignored; stop outside CLEAR/RUN SHALL be ignored.
REQ-027 Presc and burst_len changes while busy SHALL have no effect on the current burst.
REQ-028 burst_len==0 SHALL run until stop or saturation; the pulse counter SHALL saturate at all-ones, not wrap.
REQ-029 gen_ena, gen_clr, done and sample_vld SHALL be mutually exclusive single-cycle pulses decoded from state.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, gen_ena=0, gen_clr=0, busy=0, done=0, sat=0, sample=16'h0000, sample_vld=0, and both counters to 0, including mid-burst.
REQ-031 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-032 presc=0, burst_len=3, start pulse at cycle 0 -> gen_clr in cycle 1; gen_ena in cycles 2-4; sample=16'h0003 with sample_vld in cycle 5; done in cycle 6; busy in cycles 1-6.
REQ-033 presc=2, burst_len=2 -> gen_ena in RUN cycles 3 and 6 (counting from 1), exactly two pulses, sample=16'h0002.
REQ-034 burst_len=0, presc=0, stop at the 5th RUN cycle -> 4 gen_ena pulses, no gen_ena in the stop cycle, sample=16'h0004, sat=0.
REQ-035 burst_len=0, presc=0, model the generator to 16'hFFFF -> sat=1, no gen_ena while gen_data=16'hFFFF, sample=16'hFFFF, done pulse; the next start clears sat.
REQ-036 rst_n low during RUN -> all outputs return to reset values asynchronously, no done pulse; start with burst_len=1 afterwards -> normal burst with sample=16'h0001.
REQ-037 start during RUN and stop in IDLE -> ignored; burst length and timing unchanged.
